// File: rtl/ram_initiator.sv
// Burst initiator that turns write/read burst requests into single-port RAM accesses.
// Optional request bounds checking is enabled by defining RAM_INITIATOR_BOUNDS_EN.
module ram_initiator #(
  parameter int unsigned MEM_DEPTH = 16,
  parameter int unsigned MEM_WIDTH = 8,
  parameter int unsigned SYNC_READ = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [MEM_DEPTH-1:0] req_addr,
  input  logic [7:0]           req_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [MEM_WIDTH-1:0] wr_data,
  output logic                 rd_valid,
  output logic [MEM_WIDTH-1:0] rd_data,
  output logic                 done,
  output logic                 err,
  output logic                 csn,
  output logic                 wen,
  output logic [MEM_DEPTH-1:0] addr,
  output logic [MEM_WIDTH-1:0] wdata,
  input  logic [MEM_WIDTH-1:0] rdata,
  output logic                 mode,
  output logic                 synch
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

  state_e               state_q, state_d;
  logic [MEM_DEPTH-1:0] addr_q, addr_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 rd_valid_q;
  logic [MEM_WIDTH-1:0] rd_data_q;
  logic                 beat_q;
  logic                 capture;
  logic                 reject;

`ifdef RAM_INITIATOR_BOUNDS_EN
  localparam int unsigned SumW = ((MEM_DEPTH > 8) ? MEM_DEPTH : 8) + 1;
  logic [SumW-1:0] end_addr;
  assign end_addr = SumW'(req_addr) + SumW'(req_len);
  // Any carry above the address width means the burst would run past the top.
  assign reject   = (end_addr[SumW-1:MEM_DEPTH] != '0);
`else
  assign reject = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    csn       = 1'b1;
    wen       = 1'b1;
    wdata     = '0;
    case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            addr_d  = req_addr;
            cnt_d   = req_len;
            state_d = req_write ? StWrite : StRead;
          end
        end
      end
      StWrite: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          csn   = 1'b0;
          wen   = 1'b0;
          wdata = wr_data;
          if (cnt_q == 8'd0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q - 8'd1;
          end
        end
      end
      StRead: begin
        csn = 1'b0;
        if (cnt_q == 8'd0) begin
          // Address is held on the last beat so DRAIN re-presents it.
          if (SYNC_READ != 0) begin
            state_d = StDrain;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 8'd1;
        end
      end
      StDrain: begin
        csn     = 1'b0;
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Synchronous RAM returns data one cycle after the beat, so capture is delayed.
  assign capture = (SYNC_READ != 0) ? beat_q : (state_q == StRead);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      beat_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_valid_q <= capture;
      beat_q     <= (state_q == StRead);
      if (capture) begin
        rd_data_q <= rdata;
      end
    end
  end

  assign addr     = addr_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign mode     = 1'b0;
  assign synch    = (SYNC_READ != 0);

endmodule

// File: tb/tb_ram_initiator.sv
// Bench for ram_initiator: one asynchronous-read and one synchronous-read instance,
// each driving a behavioural RAM, checked against a queue/array reference model.
module tb_ram_initiator;

  localparam int D = 4;
  localparam int W = 8;
`ifdef RAM_INITIATOR_BOUNDS_EN
  localparam bit Bounds = 1'b1;
`else
  localparam bit Bounds = 1'b0;
`endif

  logic         clk, rst;
  logic         req_valid [2];
  logic         req_ready [2];
  logic         req_write [2];
  logic [D-1:0] req_addr  [2];
  logic [7:0]   req_len   [2];
  logic         wr_valid  [2];
  logic         wr_ready  [2];
  logic [W-1:0] wr_data   [2];
  logic         rd_valid  [2];
  logic [W-1:0] rd_data   [2];
  logic         done      [2];
  logic         err       [2];
  logic         csn       [2];
  logic         wen       [2];
  logic [D-1:0] addr      [2];
  logic [W-1:0] wdata     [2];
  logic [W-1:0] rdata     [2];
  logic         mode      [2];
  logic         synch     [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram_initiator #(.MEM_DEPTH(D), .MEM_WIDTH(W), .SYNC_READ(g)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
      .req_addr(req_addr[g]), .req_len(req_len[g]),
      .wr_valid(wr_valid[g]), .wr_ready(wr_ready[g]), .wr_data(wr_data[g]),
      .rd_valid(rd_valid[g]), .rd_data(rd_data[g]), .done(done[g]), .err(err[g]),
      .csn(csn[g]), .wen(wen[g]), .addr(addr[g]), .wdata(wdata[g]), .rdata(rdata[g]),
      .mode(mode[g]), .synch(synch[g])
    );
  end

  // Behavioural RAMs: instance 0 reads combinationally, instance 1 reads on the clock.
  logic [W-1:0] mem [2][16];
  logic [W-1:0] rdata_sync;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 16; j++) mem[i][j] <= '0;
      rdata_sync <= '0;
    end else begin
      for (int k = 0; k < 2; k++)
        if (!csn[k] && !wen[k]) mem[k][addr[k]] <= wdata[k];
      if (!csn[1] && wen[1]) rdata_sync <= mem[1][addr[1]];
    end
  end
  assign rdata[0] = mem[0][addr[0]];
  assign rdata[1] = rdata_sync;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor of the active instance, sampled on the falling edge.
  int act = 0;
  int cyc = 0;
  int err_n = 0;
  int viol = 0;
  int wq_a[$], wq_d[$], wr_c[$], ra_a[$], ra_c[$], rv_d[$], rv_c[$], dn_c[$];
  always @(negedge clk) begin
    logic bad;
    bad = (req_ready[act] && wr_ready[act]) || mode[act] || (synch[act] != (act == 1)) ||
          (!csn[act] && !wen[act] && !wr_ready[act]) || !csn[1-act] || rd_valid[1-act];
    cyc <= cyc + 1;
    viol <= viol + int'(bad);
    if (err[act]) err_n <= err_n + 1;
    if (!csn[act] && !wen[act]) begin
      wq_a.push_back(int'(addr[act]));
      wq_d.push_back(int'(wdata[act]));
      wr_c.push_back(cyc);
    end
    if (!csn[act] && wen[act]) begin
      ra_a.push_back(int'(addr[act]));
      ra_c.push_back(cyc);
    end
    if (rd_valid[act]) begin
      rv_d.push_back(int'(rd_data[act]));
      rv_c.push_back(cyc);
    end
    if (done[act]) dn_c.push_back(cyc);
  end

  int n_pass = 0;
  int n_tot = 0;
  int bn = 0;
  int ref_mem [2][16];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int k; bit wr; int a; int len; int gap; int base; int exp_beats;
  } vec_t;

  // gap: 0 continuous, 1 two idle cycles between beats, 2 random idles before each beat.
  task automatic do_burst(input int k, input bit wr, input int a, input int len,
                          input int gap, input int base, input int exp_beats);
    int    d[$];
    int    ea[$];
    int    w0, r0, v0, n0, e0, x0, lim, g;
    bit    rej;
    string tg;
    rej = (exp_beats == 0);
    tg = $sformatf("b%0d(k%0d %s a%0d l%0d)", bn, k, wr ? "wr" : "rd", a, len);
    bn++;
    for (int i = 0; i <= len; i++)
      d.push_back(base >= 0 ? ((base + i) & 255) : int'($urandom_range(0, 255)));
    act = k;
    w0 = wq_a.size(); r0 = ra_a.size(); v0 = rv_d.size(); n0 = dn_c.size();
    e0 = err_n; x0 = viol;
    step();
    req_valid[k] = 1'b1; req_write[k] = wr; req_addr[k] = D'(a); req_len[k] = 8'(len);
    step();
    req_valid[k] = 1'b0;
    chk({tg, " req_ready"}, 64'(req_ready[k]), 64'(rej));
    if (wr && !rej) begin
      for (int i = 0; i <= len; i++) begin
        g = (gap == 1 && i > 0) ? 2 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (g) begin
          wr_valid[k] = 1'b0;
          step();
        end
        wr_valid[k] = 1'b1;
        wr_data[k] = W'(d[i]);
        step();
      end
      wr_valid[k] = 1'b0;
    end
    lim = (len + 1) * 4 + 20;
    for (int t = 0; t < lim; t++) begin
      if (dn_c.size() > n0 || err_n > e0) break;
      step();
    end
    repeat (3) step();

    chk({tg, " err"}, 64'(err_n - e0), 64'(rej));
    chk({tg, " done"}, 64'(dn_c.size() - n0), rej ? 64'd0 : 64'd1);
    if (rej) begin
      chk({tg, " ram_access"}, 64'((wq_a.size() - w0) + (ra_a.size() - r0)), 64'd0);
    end else if (wr) begin
      chk({tg, " writes"}, 64'(wq_a.size() - w0), 64'(exp_beats));
      chk({tg, " rd_valid"}, 64'(rv_d.size() - v0), 64'd0);
      for (int i = 0; i <= len && w0 + i < wq_a.size(); i++) begin
        chk({tg, $sformatf(" waddr%0d", i)}, 64'(wq_a[w0+i]), 64'((a + i) & 15));
        chk({tg, $sformatf(" wdata%0d", i)}, 64'(wq_d[w0+i]), 64'(d[i]));
      end
      if (wq_a.size() - w0 == len + 1 && dn_c.size() > n0)
        chk({tg, " done_lat"}, 64'(dn_c[n0] - wr_c[w0+len]), 64'd1);
      for (int i = 0; i <= len; i++) ref_mem[k][(a + i) & 15] = d[i];
    end else begin
      for (int i = 0; i <= len; i++) ea.push_back((a + i) & 15);
      if (k == 1) ea.push_back((a + len) & 15);
      chk({tg, " beats"}, 64'(rv_d.size() - v0), 64'(exp_beats));
      chk({tg, " raccess"}, 64'(ra_a.size() - r0), 64'(ea.size()));
      for (int i = 0; i < ea.size() && r0 + i < ra_a.size(); i++)
        chk({tg, $sformatf(" raddr%0d", i)}, 64'(ra_a[r0+i]), 64'(ea[i]));
      for (int i = 0; i <= len && v0 + i < rv_d.size(); i++)
        chk({tg, $sformatf(" rdata%0d", i)}, 64'(rv_d[v0+i]), 64'(ref_mem[k][(a + i) & 15]));
      if (rv_d.size() - v0 == len + 1 && ra_a.size() > r0 && dn_c.size() > n0) begin
        chk({tg, " rd_lat"}, 64'(rv_c[v0] - ra_c[r0]), 64'(k + 1));
        chk({tg, " rd_span"}, 64'(rv_c[v0+len] - rv_c[v0]), 64'(len));
        chk({tg, " done_last"}, 64'(dn_c[n0] - rv_c[v0+len]), 64'd0);
      end
    end
    chk({tg, " protocol"}, 64'(viol - x0), 64'd0);
  endtask

  vec_t tv [8];

  initial begin
    int w0, n0, k, wr, a, len;
    tv[0] = '{1, 1'b1, 3, 3, 0, 'hA1, 4};
    tv[1] = '{1, 1'b0, 3, 3, 0, -1, 4};
    tv[2] = '{1, 1'b1, 8, 2, 1, -1, 3};
    tv[3] = '{0, 1'b1, 14, 3, 0, -1, Bounds ? 0 : 4};
    tv[4] = '{0, 1'b0, 14, 3, 0, -1, Bounds ? 0 : 4};
    tv[5] = '{0, 1'b0, 5, 0, 0, -1, 1};
    tv[6] = '{1, 1'b1, 15, 0, 0, 'h5C, 1};
    tv[7] = '{1, 0, 13, 4, 0, -1, Bounds ? 0 : 5};
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 16; j++) ref_mem[i][j] = 0;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0; req_len[i] = '0;
      wr_valid[i] = 1'b0; wr_data[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d req_ready", i), 64'(req_ready[i]), 64'd1);
      chk($sformatf("rst%0d wr_ready", i), 64'(wr_ready[i]), 64'd0);
      chk($sformatf("rst%0d csn", i), 64'(csn[i]), 64'd1);
      chk($sformatf("rst%0d wen", i), 64'(wen[i]), 64'd1);
      chk($sformatf("rst%0d addr", i), 64'(addr[i]), 64'd0);
      chk($sformatf("rst%0d wdata", i), 64'(wdata[i]), 64'd0);
      chk($sformatf("rst%0d rd_valid", i), 64'(rd_valid[i]), 64'd0);
      chk($sformatf("rst%0d rd_data", i), 64'(rd_data[i]), 64'd0);
      chk($sformatf("rst%0d done", i), 64'(done[i]), 64'd0);
      chk($sformatf("rst%0d err", i), 64'(err[i]), 64'd0);
      chk($sformatf("rst%0d mode", i), 64'(mode[i]), 64'd0);
      chk($sformatf("rst%0d synch", i), 64'(synch[i]), 64'(i));
    end
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      do_burst(tv[i].k, tv[i].wr, tv[i].a, tv[i].len, tv[i].gap, tv[i].base, tv[i].exp_beats);

    // Reset during the third beat of an eight-beat write.
    act = 1;
    w0 = wq_a.size(); n0 = dn_c.size();
    step();
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = '0; req_len[1] = 8'd7;
    step();
    req_valid[1] = 1'b0; wr_valid[1] = 1'b1; wr_data[1] = 8'h11;
    step();
    wr_data[1] = 8'h22;
    step();
    wr_data[1] = 8'h33;
    #2 rst = 1'b1;
    #1;
    chk("midrst csn", 64'(csn[1]), 64'd1);
    chk("midrst wen", 64'(wen[1]), 64'd1);
    chk("midrst addr", 64'(addr[1]), 64'd0);
    wr_valid[1] = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 16; j++) ref_mem[i][j] = 0;
    repeat (5) step();
    chk("midrst writes", 64'(wq_a.size() - w0), 64'd2);
    chk("midrst done", 64'(dn_c.size() - n0), 64'd0);

    for (int n = 0; n < 30; n++) begin
      k = int'($urandom_range(0, 1));
      wr = int'($urandom_range(0, 1));
      a = int'($urandom_range(0, 15));
      len = int'($urandom_range(0, 20));
      do_burst(k, wr != 0, a, len, 2, -1, (Bounds && a + len > 15) ? 0 : len + 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/ram_initiator.md
RAM_INITIATOR -- requirements
Module: ram_initiator

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 16, address width in bits of the RAM port.
REQ-002 SHALL have parameter MEM_WIDTH, default 8, data width in bits.
REQ-003 SHALL have parameter SYNC_READ, default 1: 0 = RAM asynchronous read, 1 = RAM synchronous read.
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  burst request valid
- req_ready  out  1  request accepted when both high
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  MEM_DEPTH  burst start address
- req_len  in  8  burst beats minus one (0..255)
- wr_valid  in  1  write beat data valid
- wr_ready  out  1  write beat consumed when both high
- wr_data  in  MEM_WIDTH  write beat data
- rd_valid  out  1  read beat data valid, single-cycle pulse per beat
- rd_data  out  MEM_WIDTH  read beat data
- done  out  1  one-cycle pulse when burst completes
- err  out  1  one-cycle pulse when request rejected
- csn  out  1  RAM chip select, active low
- wen  out  1  RAM write enable, active low
- addr  out  MEM_DEPTH  RAM address
- wdata  out  MEM_WIDTH  RAM write data
- rdata  in  MEM_WIDTH  RAM read data
- mode  out  1  RAM mode, constant 0 (read first)
- synch  out  1  RAM synch, constant SYNC_READ

Function
REQ-005 SHALL implement FSM states IDLE, WRITE, READ, DRAIN.
REQ-006 IDLE: req_ready=1, csn=1, wen=1; on req_valid go to WRITE (req_write=1) or READ (req_write=0); latch addr=req_addr, beat counter=req_len.
REQ-007 WRITE: wr_ready=1; csn=0 and wen=0 only in cycles with wr_valid=1, wdata=wr_data; otherwise csn=1, wen=1.
REQ-008 WRITE: each accepted beat increments addr by 1 and decrements the counter; the beat with counter=0 returns to IDLE and pulses done next cycle.
REQ-009 READ: csn=0, wen=1, one beat per cycle, no stalls; addr increments each cycle.
REQ-010 SYNC_READ=0: rdata sampled in beat cycle; rd_data/rd_valid registered, 1-cycle latency; after last beat go IDLE, done coincident with last rd_valid.
REQ-011 SYNC_READ=1: 2-cycle latency; after last beat enter DRAIN for one cycle holding csn=0, wen=1, addr=last address; last rd_valid and done in cycle after DRAIN.
REQ-012 Address arithmetic SHALL be modulo 2^MEM_DEPTH (wrap from all-ones to 0) unless REQ-018 applies.
REQ-013 req_ready SHALL be 0 outside IDLE; wr_ready SHALL be 0 outside WRITE.
REQ-014 rd_valid SHALL never assert for write bursts; csn=0 with wen=0 SHALL never occur outside WRITE.
REQ-015 req_len=0 SHALL perform exactly one beat.

Reset
REQ-016 On rst: state IDLE, csn=1, wen=1, addr=0, wdata=0, rd_data=0, rd_valid=0, done=0, err=0, counter=0; applies immediately, mid-burst bursts abandoned with no done.
REQ-017 First request SHALL be accepted in the first clock edge after rst deasserts with req_valid=1.

Configuration
REQ-018 With RAM_INITIATOR_BOUNDS_EN defined: a request where req_addr+req_len exceeds 2^MEM_DEPTH-1 SHALL be rejected in IDLE: err pulses next cycle, no RAM access, state stays IDLE, req_ready stays 1.
REQ-019 Without RAM_INITIATOR_BOUNDS_EN: err SHALL be tied 0 and such bursts wrap per REQ-012.

Verification
REQ-020 Write burst addr=3, len=3, data 0xA1..0xA4, wr_valid continuous -> csn/wen low 4 cycles, addr 3,4,5,6, done 1 cycle after last beat.
REQ-021 Write burst len=2 with wr_valid low for 2 cycles between beats -> csn high in gap cycles, exactly 3 RAM writes, addresses consecutive.
REQ-022 SYNC_READ=1 read addr=3 len=3 after REQ-020 -> rd_valid 4 consecutive cycles, rd_data 0xA1..0xA4, first rd_valid 2 cycles after first beat, done with last.
REQ-023 MEM_DEPTH=4, read addr=14 len=3 -> without macro addr 14,15,0,1; with RAM_INITIATOR_BOUNDS_EN err pulse, csn stays high, no done.
REQ-024 rst asserted during 3rd beat of len=7 write -> csn=1 immediately, no done, next request accepted normally.
REQ-025 SYNC_READ=0 read len=0 -> single beat, rd_valid and done 1 cycle after the beat.
